// File: rtl/spi_regfile_slave.sv
// spi_regfile_slave: SPI mode-3 slave exposing a register file for reads and writes.
// Define SPI_REGFILE_BURST_EN to auto-increment the address across consecutive words.
module spi_regfile_slave #(
   parameter int DATA_W      = 32,
   parameter int NUM_REGS    = 8,
   parameter int SYNC_STAGES = 3
) (
   input  logic                         clock,
   input  logic                         rst,
   input  logic                         sck,
   input  logic                         mosi,
   input  logic                         ssel,
   output logic                         miso,
   output logic [NUM_REGS*DATA_W-1:0]   regs_out,
   output logic                         wr_pulse,
   output logic [6:0]                   wr_addr,
   output logic                         rd_pulse,
   output logic [6:0]                   rd_addr,
   output logic                         frame_err
);
   localparam int AW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
   typedef enum logic [1:0] {IDLE, CMD, DATA, HOLD} state_t;
`ifdef SPI_REGFILE_BURST_EN
   localparam state_t WORD_END = DATA;
`else
   localparam state_t WORD_END = HOLD;
`endif
   state_t state, nxt;
   logic [SYNC_STAGES-1:0] sck_q, mosi_q, ssel_q;
   logic [SYNC_STAGES:0] vld;
   logic sck_s, mosi_s, ssel_s, sck_d, ssel_d, armed, word_done, rw;
   logic rise, fall, s_rise, s_fall, last, abort, cmd_ok, addr_ok, ld_ok;
   logic [6:0] cnt, addr, cmd_addr, nxt_addr, ld_addr;
   logic [DATA_W-1:0] rx, tx, ld_val, rx_nxt;
   logic [DATA_W-1:0] regs [NUM_REGS];

   assign sck_s    = sck_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_q[SYNC_STAGES-1];
   assign ssel_s   = ssel_q[SYNC_STAGES-1];
   assign rise     = sck_s & ~sck_d;
   assign fall     = ~sck_s & sck_d;
   assign s_rise   = ssel_s & ~ssel_d;
   assign s_fall   = ~ssel_s & ssel_d & armed;
   assign last     = cnt == 7'(DATA_W-1);
   assign rx_nxt   = {rx[DATA_W-2:0], mosi_s};
   assign cmd_addr = {rx[5:0], mosi_s};
   assign cmd_ok   = {1'b0, cmd_addr} < 8'(NUM_REGS);
   assign addr_ok  = {1'b0, addr} < 8'(NUM_REGS);
   assign nxt_addr = addr == 7'(NUM_REGS-1) ? 7'd0 : addr + 7'd1;
   assign ld_addr  = state == CMD ? cmd_addr : nxt_addr;
   assign ld_ok    = {1'b0, ld_addr} < 8'(NUM_REGS);
   assign ld_val   = ld_ok ? regs[ld_addr[AW-1:0]] : '0;
   // a completed word followed by ssel rising is a clean end of frame
   assign abort    = s_rise & (state == CMD | (state == DATA & ~(cnt == 7'd0 & word_done)));

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
      assign regs_out[k*DATA_W +: DATA_W] = regs[k];
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = s_fall ? CMD : IDLE;
         CMD:     nxt = (rise && cnt == 7'd7) ? DATA : CMD;
         DATA:    nxt = (rise && last) ? WORD_END : DATA;
         default: nxt = HOLD;
      endcase
      if (s_rise) nxt = IDLE;
   end

   always_ff @(posedge clock) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   always_ff @(posedge clock) begin
      if (!rst) begin
         sck_q <= '1;
         ssel_q <= '1;
         mosi_q <= '0;
         vld <= '0;
         sck_d <= 1'b1;
         ssel_d <= 1'b1;
         armed <= 1'b0;
         word_done <= 1'b0;
         rw <= 1'b0;
         cnt <= '0;
         addr <= '0;
         rx <= '0;
         tx <= '0;
         miso <= 1'b0;
         wr_pulse <= 1'b0;
         wr_addr <= '0;
         rd_pulse <= 1'b0;
         rd_addr <= '0;
         frame_err <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         sck_q <= {sck_q[SYNC_STAGES-2:0], sck};
         mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
         ssel_q <= {ssel_q[SYNC_STAGES-2:0], ssel};
         vld <= {vld[SYNC_STAGES-1:0], 1'b1};
         sck_d <= sck_s;
         ssel_d <= ssel_s;
         // a frame already in progress at reset release is skipped until ssel is seen high
         armed <= armed | (vld[SYNC_STAGES] & ssel_s);
         wr_pulse <= 1'b0;
         rd_pulse <= 1'b0;
         frame_err <= abort;
         if (s_fall) begin
            cnt <= '0;
            word_done <= 1'b0;
            miso <= 1'b0;
         end
         if (state == CMD && rise) begin
            rx <= rx_nxt;
            cnt <= cnt + 7'd1;
            if (cnt == 7'd7) begin
               cnt <= '0;
               rw <= rx[6];
               addr <= cmd_addr;
               tx <= rx[6] ? '0 : ld_val;
               if (!cmd_ok) frame_err <= 1'b1;
               else if (!rx[6]) begin
                  rd_pulse <= 1'b1;
                  rd_addr <= cmd_addr;
               end
            end
         end
         if (state == DATA && rise) begin
            rx <= rx_nxt;
            cnt <= cnt + 7'd1;
            if (last) begin
               cnt <= '0;
               word_done <= 1'b1;
               if (rw && addr_ok) begin
                  regs[addr[AW-1:0]] <= rx_nxt;
                  wr_pulse <= 1'b1;
                  wr_addr <= addr;
               end
`ifdef SPI_REGFILE_BURST_EN
               addr <= nxt_addr;
               if (!rw) begin
                  tx <= ld_val;
                  rd_pulse <= ld_ok;
                  if (ld_ok) rd_addr <= nxt_addr;
               end
`else
               miso <= 1'b0;
`endif
            end
         end
         if (state == DATA && fall && !rw) begin
            miso <= tx[DATA_W-1];
            tx <= {tx[DATA_W-2:0], 1'b0};
         end
         if (s_rise) miso <= 1'b0;
      end
   end
endmodule

// File: tb/tb_spi_regfile_slave.sv
// tb_spi_regfile_slave: randomized self-checking bench with a register-array reference model.
module tb_spi_regfile_slave;
   localparam int DW = 32;
   localparam int NR = 8;
   localparam int HP = 80;
   logic clock = 0, rst = 0, sck = 1, mosi = 0, ssel = 1;
   logic miso, wr_pulse, rd_pulse, frame_err;
   logic [6:0] wr_addr, rd_addr;
   logic [NR*DW-1:0] regs_out;
   logic [DW-1:0] mdl [NR];
   int checks = 0, errors = 0;
   int wr_n = 0, rd_n = 0, err_n = 0, w0, r0, f0;
   logic [6:0] last_wa = 0, last_ra = 0;

   spi_regfile_slave dut (
      .clock(clock), .rst(rst), .sck(sck), .mosi(mosi), .ssel(ssel), .miso(miso),
      .regs_out(regs_out), .wr_pulse(wr_pulse), .wr_addr(wr_addr),
      .rd_pulse(rd_pulse), .rd_addr(rd_addr), .frame_err(frame_err)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (wr_pulse) begin wr_n++; last_wa = wr_addr; end
      if (rd_pulse) begin rd_n++; last_ra = rd_addr; end
      if (frame_err) err_n++;
   end

   task automatic check(input string tag, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [NR*DW-1:0] packed_mdl();
      logic [NR*DW-1:0] v;
      for (int i = 0; i < NR; i++) v[i*DW +: DW] = mdl[i];
      return v;
   endfunction

   task automatic snap();
      w0 = wr_n; r0 = rd_n; f0 = err_n;
   endtask

   task automatic xfer(input logic [63:0] v, input int n, output logic [63:0] r);
      r = '0;
      for (int i = n - 1; i >= 0; i--) begin
         sck = 0; mosi = v[i];
         #HP;
         r[i] = miso;
         sck = 1;
         #HP;
      end
   endtask

   task automatic sel_on();
      ssel = 0; #HP;
   endtask

   task automatic sel_off();
      #HP; ssel = 1; #(3*HP);
   endtask

   task automatic frame(input logic [7:0] cmd, input int n, input logic [63:0] d, output logic [63:0] cm, output logic [63:0] dm);
      sel_on();
      xfer({56'd0, cmd}, 8, cm);
      xfer(d, n, dm);
      sel_off();
   endtask

   initial begin
      logic [63:0] cm, dm, dm2, dm3;
      logic [6:0] a;
      logic [DW-1:0] d;
      bit wr;
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      repeat (4) @(negedge clock);
      check("reset_regs", regs_out, '0);
      check("reset_miso", {255'd0, miso}, '0);
      check("reset_strobes", {252'd0, wr_pulse, rd_pulse, frame_err}, '0);
      rst = 1;
      repeat (10) @(negedge clock);

      snap();
      frame(8'h83, 32, 64'hDEADBEEF, cm, dm);
      mdl[3] = 32'hDEADBEEF;
      check("wr_count", wr_n - w0, 1);
      check("wr_addr", {249'd0, last_wa}, 3);
      check("wr_regs", regs_out, packed_mdl());
      check("wr_cmd_miso", cm, 0);
      check("wr_data_miso", dm, 0);

      snap();
      frame(8'h03, 32, 64'h0, cm, dm);
      check("rd_data", dm, 64'hDEADBEEF);
      check("rd_cmd_miso", cm, 0);
      check("rd_count", rd_n - r0, 1);
      check("rd_addr", {249'd0, last_ra}, 3);
      check("rd_ferr", err_n - f0, 0);

      snap();
      frame(8'h81, 20, 64'hABCDE, cm, dm);
      check("abort_wr", wr_n - w0, 0);
      check("abort_ferr", err_n - f0, 1);
      check("abort_regs", regs_out, packed_mdl());

      snap();
      frame(8'h8A, 32, 64'h12345678, cm, dm);
      check("rng_wr", wr_n - w0, 0);
      check("rng_wr_ferr", err_n - f0, 1);
      check("rng_regs", regs_out, packed_mdl());
      snap();
      frame(8'h0A, 32, 64'h0, cm, dm);
      check("rng_rd_data", dm, 0);
      check("rng_rd_ferr", err_n - f0, 1);
      check("rng_rd_count", rd_n - r0, 0);

      snap();
      sel_on();
      xfer(64'h86, 8, cm);
      xfer(64'hAAAA0001, 32, dm);
      xfer(64'hBBBB0002, 32, dm2);
      xfer(64'hCCCC0003, 32, dm3);
      sel_off();
      mdl[6] = 32'hAAAA0001;
`ifdef SPI_REGFILE_BURST_EN
      mdl[7] = 32'hBBBB0002;
      mdl[0] = 32'hCCCC0003;
      check("burst_count", wr_n - w0, 3);
      check("burst_last_addr", {249'd0, last_wa}, 0);
`else
      check("burst_count", wr_n - w0, 1);
      check("burst_last_addr", {249'd0, last_wa}, 6);
`endif
      check("burst_regs", regs_out, packed_mdl());
      check("burst_ferr", err_n - f0, 0);
      check("burst_miso", dm | dm2 | dm3, 0);

      for (int t = 0; t < 20; t++) begin
         a = 7'($urandom_range(0, NR + 1));
         wr = 1'($urandom_range(0, 1));
         d = DW'($urandom);
         snap();
         frame({wr, a}, 32, {32'd0, d}, cm, dm);
         if (wr && a < NR) mdl[a] = d;
         check("rnd_wr", wr_n - w0, (wr && a < NR) ? 1 : 0);
         check("rnd_rd", rd_n - r0, (!wr && a < NR) ? 1 : 0);
         check("rnd_ferr", err_n - f0, (a >= NR) ? 1 : 0);
         check("rnd_miso", dm, (!wr && a < NR) ? {32'd0, mdl[a]} : 64'd0);
         check("rnd_regs", regs_out, packed_mdl());
      end

      snap();
      sel_on();
      xfer(64'h85, 8, cm);
      xfer(64'h3FF, 10, dm);
      @(negedge clock) rst = 0;
      @(negedge clock) rst = 1;
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      check("mid_rst_regs", regs_out, '0);
      check("mid_rst_miso", {255'd0, miso}, '0);
      xfer(64'h3FFFFF, 22, dm);
      sel_off();
      check("mid_rst_wr", wr_n - w0, 0);
      check("mid_rst_ferr", err_n - f0, 0);
      check("mid_rst_after", regs_out, packed_mdl());
      snap();
      frame(8'h82, 32, 64'h5A5AC3C3, cm, dm);
      mdl[2] = 32'h5A5AC3C3;
      check("post_rst_wr", wr_n - w0, 1);
      check("post_rst_regs", regs_out, packed_mdl());
      frame(8'h02, 32, 64'h0, cm, dm);
      check("post_rst_rd", dm, 64'h5A5AC3C3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_regfile_slave.md
SPI_REGFILE_SLAVE -- requirements
Module: spi_regfile_slave

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits; multiple of 8, range 8..64.
REQ-002 Parameter NUM_REGS, default 8, number of registers; range 1..128.
REQ-003 Parameter SYNC_STAGES, default 3, synchroniser depth for sck/mosi/ssel; minimum 2.
REQ-004 clock  input  1  system clock; all state on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-low.
REQ-006 sck  input  1  SPI clock, asynchronous to clock; idles high.
REQ-007 mosi  input  1  SPI data in, MSB first.
REQ-008 ssel  input  1  SPI chip select, active-low.
REQ-009 miso  output  1  SPI data out, MSB first.
REQ-010 regs_out  output  NUM_REGS*DATA_W  flattened register file; register k at bits [k*DATA_W +: DATA_W].
REQ-011 wr_pulse  output  1  one-cycle strobe, a register was written.
REQ-012 wr_addr  output  7  address of the write flagged by wr_pulse.
REQ-013 rd_pulse  output  1  one-cycle strobe, a register was latched for readout.
REQ-014 rd_addr  output  7  address of the read flagged by rd_pulse.
REQ-015 frame_err  output  1  one-cycle strobe for an aborted frame or out-of-range address.

Function
REQ-016 sck, mosi and ssel SHALL each pass through SYNC_STAGES flops; edges SHALL be detected on the synchronised signals only.
REQ-017 SPI mode 3: mosi SHALL be sampled on the detected sck rising edge, and miso SHALL change on the detected sck falling edge.
REQ-018 sck high and low phases SHALL each be at least SYNC_STAGES+2 clock periods; faster sck is unsupported.
REQ-019 Frame format: command byte {rw, addr[6:0]} followed by DATA_W data bits; rw=1 is a write, rw=0 is a read.
REQ-020 FSM states: IDLE, CMD, DATA, HOLD. ssel falling moves IDLE->CMD. The 8th command bit moves CMD->DATA. The last data bit moves DATA->HOLD, or re-enters DATA when burst is enabled (REQ-031). ssel rising moves any state ->IDLE.
REQ-021 Write: one clock after the rising-edge detect of data bit DATA_W, the register SHALL update, wr_pulse SHALL be high for 1 cycle, and wr_addr SHALL equal addr.
REQ-022 Read: one clock after the rising-edge detect of command bit 8, the register SHALL be copied into a shift register, rd_pulse SHALL be high for 1 cycle, and rd_addr SHALL equal addr. The MSB SHALL drive miso from the next sck falling edge.
REQ-023 miso SHALL be 0 during the command byte, during HOLD, during a write, and whenever ssel is high.
REQ-024 addr >= NUM_REGS: a write SHALL be discarded, a read SHALL shift out all zeros, frame_err SHALL pulse once at the end of the command byte, and wr_pulse/rd_pulse SHALL stay low.
REQ-025 ssel rising in CMD or mid-word in DATA: the partial word SHALL be discarded, no register SHALL change, and frame_err SHALL pulse once.
REQ-026 ssel rising exactly after a completed word SHALL NOT raise frame_err.
REQ-027 In HOLD, further sck edges SHALL be ignored until ssel rises.
REQ-028 If a wr_pulse and a frame_err fall in the same cycle, both SHALL be asserted.

Reset
REQ-029 While rst=0: all registers, the shift register and all outputs SHALL be 0, and the FSM SHALL be in IDLE; synchroniser flops SHALL also clear, with ssel synchronisers clearing to 1 and sck to 1.
REQ-030 After rst is released mid-frame, the block SHALL ignore traffic until ssel has been observed high, and no frame_err SHALL be raised for that truncated frame.

Configuration
REQ-031 Macro SPI_REGFILE_BURST_EN: when defined, after each completed word with ssel still low, addr SHALL increment and wrap from NUM_REGS-1 to 0. Further words SHALL write, or read out, consecutive registers, with one wr_pulse/rd_pulse per word. When undefined, the FSM SHALL enter HOLD after the first word.

Verification
REQ-032 Write: 0x83,DE,AD,BE,EF -> one wr_pulse with wr_addr=3; regs_out reg3=0xDEADBEEF; all other registers 0.
REQ-033 Read after REQ-032: 0x03 plus 32 sck cycles -> miso shifts 0xDEADBEEF; one rd_pulse with rd_addr=3; frame_err stays 0.
REQ-034 Abort: 0x81 then 20 data bits, then ssel high -> no wr_pulse; reg1 unchanged; one frame_err.
REQ-035 Range check (NUM_REGS=8): 0x8A plus a word -> no write and one frame_err; read 0x0A -> miso all zeros and one frame_err.
REQ-036 Burst: 0x86 plus 3 words A,B,C -> with macro defined: reg6=A, reg7=B, reg0=C and 3 wr_pulses; with macro undefined: only reg6=A and 1 wr_pulse.
REQ-037 Reset: rst=0 for 1 cycle mid-word -> regs_out=0 and miso=0; the remaining bits of that frame are ignored; the next full frame works.
